// File: rtl/sa_os_tile_ctrl.sv
// sa_os_tile_ctrl -- output-stationary systolic tile controller.
//
// A ROWS x COLS grid of signed WIDTH-bit MAC processing elements. A operands
// enter per row and are forwarded to the right. B operands enter per column
// and are forwarded downward. Each PE keeps its own ACC_W-bit accumulator.
// A job is started with start/k_len. K input beats are accepted with
// in_valid/in_ready. The array is then flushed with zero operands. Finally the
// results are drained one row at a time with out_valid/out_ready.
//
// Ports:
//   CLK        clock, rising edge
//   RST        asynchronous reset, active low
//   start      one-cycle job request, sampled only while idle
//   k_len      reduction length K, sampled with start
//   a_in       A vector, row r at [r*WIDTH +: WIDTH]
//   b_in       B vector, column c at [c*WIDTH +: WIDTH]
//   in_valid   input beat valid
//   in_ready   tile accepts a beat (LOAD only)
//   out_data   one result row, column c at [c*ACC_W +: ACC_W]
//   out_row    index of the row currently on out_data
//   out_valid  out_data valid
//   out_ready  consumer accepts the row
//   busy       high whenever a job is in progress
//   done       one-cycle pulse after the last row has been accepted
//
// Build option: define SA_ACC_SAT_EN to make each PE accumulator saturate
// instead of wrapping. Saturation is sticky until the next start clears it.
module sa_os_tile_ctrl #(
  parameter int ROWS  = 4,
  parameter int COLS  = 4,
  parameter int WIDTH = 8,
  parameter int ACC_W = 2*WIDTH+8,
  parameter int K_W   = 8
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     start,
  input  logic [K_W-1:0]           k_len,
  input  logic [ROWS*WIDTH-1:0]    a_in,
  input  logic [COLS*WIDTH-1:0]    b_in,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [COLS*ACC_W-1:0]    out_data,
  output logic [$clog2(ROWS)-1:0]  out_row,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     busy,
  output logic                     done
);

  localparam int ROW_W = $clog2(ROWS);
  localparam int FL_W  = $clog2(ROWS+COLS);
  // Flush counter runs 0..ROWS+COLS-2 while stepping. The terminal value is a
  // non-stepping cycle that hands over to DRAIN.
  localparam logic [FL_W-1:0] FLUSH_LAST = FL_W'(ROWS+COLS-1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_FLUSH, S_DRAIN} state_t;

  state_t              state_reg;
  logic [K_W-1:0]      k_len_reg;
  logic [K_W-1:0]      beat_cnt_reg;
  logic [FL_W-1:0]     flush_cnt_reg;
  logic [ROW_W-1:0]    out_row_reg;
  logic                in_ready_reg;
  logic                out_valid_reg;
  logic                busy_reg;
  logic                done_reg;

  logic                step;
  logic                clr;
  logic                inject_zero;

  // Every register in the array (skew, forwarding, accumulators) moves only on
  // a step. The start edge clears all of them so no earlier job can leak into
  // this one.
  assign clr         = (state_reg == S_IDLE) && start;
  assign step        = ((state_reg == S_LOAD) && in_valid) ||
                       ((state_reg == S_FLUSH) && (flush_cnt_reg != FLUSH_LAST));
  assign inject_zero = (state_reg == S_FLUSH);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_reg     <= S_IDLE;
      k_len_reg     <= '0;
      beat_cnt_reg  <= '0;
      flush_cnt_reg <= '0;
      out_row_reg   <= '0;
      in_ready_reg  <= 1'b0;
      out_valid_reg <= 1'b0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (start) begin
            k_len_reg     <= k_len;
            beat_cnt_reg  <= '0;
            flush_cnt_reg <= '0;
            busy_reg      <= 1'b1;
            if (k_len != '0) begin
              state_reg    <= S_LOAD;
              in_ready_reg <= 1'b1;
            end else begin
              // Nothing to accumulate: the cleared array is drained directly.
              state_reg     <= S_DRAIN;
              out_valid_reg <= 1'b1;
              out_row_reg   <= '0;
            end
          end
        end
        S_LOAD: begin
          if (in_valid) begin
            if (beat_cnt_reg == k_len_reg - K_W'(1)) begin
              state_reg    <= S_FLUSH;
              in_ready_reg <= 1'b0;
              beat_cnt_reg <= '0;
            end else begin
              beat_cnt_reg <= beat_cnt_reg + K_W'(1);
            end
          end
        end
        S_FLUSH: begin
          if (flush_cnt_reg == FLUSH_LAST) begin
            state_reg     <= S_DRAIN;
            flush_cnt_reg <= '0;
            out_valid_reg <= 1'b1;
            out_row_reg   <= '0;
          end else begin
            flush_cnt_reg <= flush_cnt_reg + FL_W'(1);
          end
        end
        S_DRAIN: begin
          if (out_ready) begin
            if (out_row_reg == ROW_W'(ROWS-1)) begin
              state_reg     <= S_IDLE;
              out_valid_reg <= 1'b0;
              out_row_reg   <= '0;
              busy_reg      <= 1'b0;
              done_reg      <= 1'b1;
            end else begin
              out_row_reg <= out_row_reg + ROW_W'(1);
            end
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------- skew
  logic signed [WIDTH-1:0] a_inj [ROWS];
  logic signed [WIDTH-1:0] b_inj [COLS];

  genvar gi, gj;
  generate
    for (gi = 0; gi < ROWS; gi++) begin : g_a_skew
      logic signed [WIDTH-1:0] a_now;
      assign a_now = inject_zero ? '0 : $signed(a_in[gi*WIDTH +: WIDTH]);
      if (gi == 0) begin : g_direct
        assign a_inj[gi] = a_now;
      end else begin : g_delay
        logic signed [WIDTH-1:0] sr_reg [gi];
        always_ff @(posedge CLK or negedge RST) begin
          if (!RST) begin
            for (int i = 0; i < gi; i++) sr_reg[i] <= '0;
          end else if (clr) begin
            for (int i = 0; i < gi; i++) sr_reg[i] <= '0;
          end else if (step) begin
            sr_reg[0] <= a_now;
            for (int i = 1; i < gi; i++) sr_reg[i] <= sr_reg[i-1];
          end
        end
        assign a_inj[gi] = sr_reg[gi-1];
      end
    end

    for (gi = 0; gi < COLS; gi++) begin : g_b_skew
      logic signed [WIDTH-1:0] b_now;
      assign b_now = inject_zero ? '0 : $signed(b_in[gi*WIDTH +: WIDTH]);
      if (gi == 0) begin : g_direct
        assign b_inj[gi] = b_now;
      end else begin : g_delay
        logic signed [WIDTH-1:0] sr_reg [gi];
        always_ff @(posedge CLK or negedge RST) begin
          if (!RST) begin
            for (int i = 0; i < gi; i++) sr_reg[i] <= '0;
          end else if (clr) begin
            for (int i = 0; i < gi; i++) sr_reg[i] <= '0;
          end else if (step) begin
            sr_reg[0] <= b_now;
            for (int i = 1; i < gi; i++) sr_reg[i] <= sr_reg[i-1];
          end
        end
        assign b_inj[gi] = sr_reg[gi-1];
      end
    end
  endgenerate

  // ---------------------------------------------------------------- PE grid
  logic signed [WIDTH-1:0] x_fwd [ROWS][COLS-1];
  logic signed [WIDTH-1:0] y_fwd [ROWS-1][COLS];
  logic signed [ACC_W-1:0] acc_w [ROWS][COLS];

`ifdef SA_ACC_SAT_EN
  // Wide enough to hold any accumulator plus any full product without overflow.
  localparam int EXT_W = ACC_W + 2*WIDTH + 1;
  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
`endif

  generate
    for (gi = 0; gi < ROWS; gi++) begin : g_row
      for (gj = 0; gj < COLS; gj++) begin : g_pe
        logic signed [WIDTH-1:0] x_in;
        logic signed [WIDTH-1:0] y_in;
        logic signed [ACC_W-1:0] acc_reg;
        logic signed [ACC_W-1:0] acc_next;

        if (gj == 0) begin : g_xsrc
          assign x_in = a_inj[gi];
        end else begin : g_xsrc
          assign x_in = x_fwd[gi][gj-1];
        end
        if (gi == 0) begin : g_ysrc
          assign y_in = b_inj[gj];
        end else begin : g_ysrc
          assign y_in = y_fwd[gi-1][gj];
        end

        // The last column has nobody to forward x to, and the last row has
        // nobody to forward y to, so those registers are omitted.
        if (gj < COLS-1) begin : g_x
          logic signed [WIDTH-1:0] x_reg;
          always_ff @(posedge CLK or negedge RST) begin
            if (!RST)      x_reg <= '0;
            else if (clr)  x_reg <= '0;
            else if (step) x_reg <= x_in;
          end
          assign x_fwd[gi][gj] = x_reg;
        end
        if (gi < ROWS-1) begin : g_y
          logic signed [WIDTH-1:0] y_reg;
          always_ff @(posedge CLK or negedge RST) begin
            if (!RST)      y_reg <= '0;
            else if (clr)  y_reg <= '0;
            else if (step) y_reg <= y_in;
          end
          assign y_fwd[gi][gj] = y_reg;
        end

`ifdef SA_ACC_SAT_EN
        logic                    sat_reg;
        logic                    sat_hit;
        logic signed [EXT_W-1:0] sum_ext;
        always_comb begin
          sum_ext  = EXT_W'(acc_reg) + EXT_W'(x_in) * EXT_W'(y_in);
          sat_hit  = 1'b0;
          acc_next = acc_reg;
          if (!sat_reg) begin
            if (sum_ext > EXT_W'(ACC_MAX)) begin
              acc_next = ACC_MAX;
              sat_hit  = 1'b1;
            end else if (sum_ext < EXT_W'(ACC_MIN)) begin
              acc_next = ACC_MIN;
              sat_hit  = 1'b1;
            end else begin
              acc_next = ACC_W'(sum_ext);
            end
          end
        end
        always_ff @(posedge CLK or negedge RST) begin
          if (!RST) begin
            acc_reg <= '0;
            sat_reg <= 1'b0;
          end else if (clr) begin
            acc_reg <= '0;
            sat_reg <= 1'b0;
          end else if (step) begin
            acc_reg <= acc_next;
            sat_reg <= sat_reg | sat_hit;
          end
        end
`else
        // Operands sign-extended to ACC_W: the product wraps modulo 2^ACC_W.
        assign acc_next = acc_reg + ACC_W'(x_in) * ACC_W'(y_in);
        always_ff @(posedge CLK or negedge RST) begin
          if (!RST)      acc_reg <= '0;
          else if (clr)  acc_reg <= '0;
          else if (step) acc_reg <= acc_next;
        end
`endif
        assign acc_w[gi][gj] = acc_reg;
      end
    end
  endgenerate

  // Accumulators hold still during DRAIN, so this mux is stable while stalled.
  always_comb begin
    out_data = '0;
    for (int c = 0; c < COLS; c++) begin
      out_data[c*ACC_W +: ACC_W] = acc_w[out_row_reg][c];
    end
  end

  assign in_ready  = in_ready_reg;
  assign out_valid = out_valid_reg;
  assign out_row   = out_row_reg;
  assign busy      = busy_reg;
  assign done      = done_reg;

endmodule

// File: tb/tb_sa_os_tile_ctrl.sv
// Testbench for sa_os_tile_ctrl. The stimulus process issues jobs and pushes
// the expected result rows into a queue. A separate monitor checks every
// cycle in which out_valid is high against the head of that queue.
module tb_sa_os_tile_ctrl;
  localparam int ROWS  = 4;
  localparam int COLS  = 4;
  localparam int WIDTH = 8;
  localparam int ACC_W = 2*WIDTH+4;   // small enough that a long job can overflow
  localparam int K_W   = 8;
  localparam int ROW_W = $clog2(ROWS);
  localparam int MAXK  = 64;

  logic                    CLK = 1'b0;
  logic                    RST = 1'b0;
  logic                    start = 1'b0;
  logic [K_W-1:0]          k_len = '0;
  logic [ROWS*WIDTH-1:0]   a_in = '0;
  logic [COLS*WIDTH-1:0]   b_in = '0;
  logic                    in_valid = 1'b0;
  logic                    in_ready;
  logic [COLS*ACC_W-1:0]   out_data;
  logic [ROW_W-1:0]        out_row;
  logic                    out_valid;
  logic                    out_ready = 1'b1;
  logic                    busy;
  logic                    done;

  sa_os_tile_ctrl #(.ROWS(ROWS), .COLS(COLS), .WIDTH(WIDTH), .ACC_W(ACC_W), .K_W(K_W)) dut (
    .CLK(CLK), .RST(RST), .start(start), .k_len(k_len), .a_in(a_in), .b_in(b_in),
    .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data), .out_row(out_row),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy), .done(done)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int                     row;
    logic [COLS*ACC_W-1:0]  data;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;
  int   done_cnt = 0;
  bit   done_due = 1'b0;
  bit   mon_en = 1'b1;
  int   rdy_mode = 0;        // 0: always ready, 1: toggle, 2: random
  int   ka [MAXK][ROWS];
  int   kb [MAXK][COLS];

  // Reference model: plain integer dot products, with the accumulator
  // behaviour (wrap or sticky saturation) applied beat by beat.
  function automatic void push_expected(input int k);
    longint acc_max = (longint'(1) <<< (ACC_W-1)) - 1;
    longint acc_min = -(longint'(1) <<< (ACC_W-1));
    for (int r = 0; r < ROWS; r++) begin
      exp_t e;
      e.row  = r;
      e.data = '0;
      for (int c = 0; c < COLS; c++) begin
        longint s = 0;
        bit     sat = 1'b0;
        for (int i = 0; i < k; i++) begin
`ifdef SA_ACC_SAT_EN
          if (!sat) begin
            s = s + longint'(ka[i][r]) * longint'(kb[i][c]);
            if (s > acc_max) begin s = acc_max; sat = 1'b1; end
            if (s < acc_min) begin s = acc_min; sat = 1'b1; end
          end
`else
          s = s + longint'(ka[i][r]) * longint'(kb[i][c]);
`endif
        end
        e.data[c*ACC_W +: ACC_W] = s[ACC_W-1:0];
      end
      q.push_back(e);
    end
  endfunction

  function automatic logic [ROWS*WIDTH-1:0] pack_a(input int i);
    logic [ROWS*WIDTH-1:0] v = '0;
    for (int r = 0; r < ROWS; r++) begin
      int t = ka[i][r];
      v[r*WIDTH +: WIDTH] = t[WIDTH-1:0];
    end
    return v;
  endfunction

  function automatic logic [COLS*WIDTH-1:0] pack_b(input int i);
    logic [COLS*WIDTH-1:0] v = '0;
    for (int c = 0; c < COLS; c++) begin
      int t = kb[i][c];
      v[c*WIDTH +: WIDTH] = t[WIDTH-1:0];
    end
    return v;
  endfunction

  // Consumer side: out_ready pattern, applied just after each rising edge.
  always @(posedge CLK) begin
    #1;
    case (rdy_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = ~out_ready;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Monitor: sampled on the falling edge, half a cycle away from updates.
  always @(negedge CLK) begin
    if (mon_en && RST) begin
      if (done_due) begin
        tests++;
        if (!(done && !out_valid && !busy)) begin
          fails++;
          $display("[TB] FAIL done_pulse: done=%0b out_valid=%0b busy=%0b, required 1/0/0",
                   done, out_valid, busy);
        end
        done_due = 1'b0;
      end else if (done) begin
        tests++;
        fails++;
        $display("[TB] FAIL spurious_done: done=1, required 0");
      end
      if (done) done_cnt++;

      if (out_valid) begin
        tests++;
        if (q.size() == 0) begin
          fails++;
          $display("[TB] FAIL unexpected_row: out_row=%0d with empty scoreboard", out_row);
        end else if (int'(out_row) != q[0].row || out_data !== q[0].data) begin
          fails++;
          $display("[TB] FAIL row_data: row=%0d data=%h, required row=%0d data=%h",
                   out_row, out_data, q[0].row, q[0].data);
          if (out_ready) void'(q.pop_front());
        end else if (out_ready) begin
          $display("[TB] row %0d accepted data=%h", out_row, out_data);
          if (q[0].row == ROWS-1) done_due = 1'b1;
          void'(q.pop_front());
        end
      end
    end
  end

  task automatic check(input string name, input longint act, input longint req);
    tests++;
    if (act != req) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic check_reset_outputs();
    @(negedge CLK);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_row", out_row, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
  endtask

  // Issue one job: start pulse, K beats (with optional random stalls and
  // garbage on the idle cycles), optionally a start poke while loading, then
  // wait for the done pulse.
  task automatic drive_job(input int k, input int stall_max, input bit poke, input bit wait_done);
    int d0;
    int t;
    d0 = done_cnt;
    push_expected(k);
    @(posedge CLK); #1;
    start = 1'b1;
    k_len = K_W'(k);
    @(posedge CLK); #1;
    start = 1'b0;
    @(negedge CLK);
    check("busy_after_start", busy, 1);
    if (k == 0) begin
      repeat (3) begin
        check("k0_no_in_ready", in_ready, 0);
        @(negedge CLK);
      end
    end
    @(posedge CLK); #1;
    for (int i = 0; i < k; i++) begin
      if (stall_max > 0) begin
        in_valid = 1'b0;
        a_in = ROWS*WIDTH'($urandom());
        b_in = COLS*WIDTH'($urandom());
        repeat ($urandom_range(0, stall_max)) begin @(posedge CLK); #1; end
      end
      in_valid = 1'b1;
      a_in = pack_a(i);
      b_in = pack_b(i);
      if (poke && i == 1) begin
        start = 1'b1;
        k_len = K_W'(3);
      end
      t = 0;
      @(negedge CLK);
      while (!in_ready && t < 200) begin @(negedge CLK); t++; end
      if (t >= 200) begin
        tests++; fails++;
        $display("[TB] FAIL beat_timeout: beat %0d of %0d not accepted", i, k);
      end
      @(posedge CLK); #1;
      start = 1'b0;
    end
    in_valid = 1'b0;
    if (wait_done) begin
      t = 0;
      while (done_cnt == d0 && t < 2000) begin @(posedge CLK); t++; end
      #1;
      if (t >= 2000) begin
        tests++; fails++;
        $display("[TB] FAIL done_timeout: job K=%0d never finished", k);
      end
      check("queue_empty", q.size(), 0);
    end
  endtask

  task automatic fill(input int k, input int av, input int bv);
    for (int i = 0; i < k; i++) begin
      for (int r = 0; r < ROWS; r++) ka[i][r] = av;
      for (int c = 0; c < COLS; c++) kb[i][c] = bv;
    end
  endtask

  initial begin
    RST = 1'b0;
    repeat (2) @(posedge CLK);
    check_reset_outputs();
    #1 RST = 1'b1;

    // K=1 outer product: result (r+1)*(c+5)
    for (int r = 0; r < ROWS; r++) ka[0][r] = r + 1;
    for (int c = 0; c < COLS; c++) kb[0][c] = c + 5;
    rdy_mode = 0;
    drive_job(1, 0, 1'b0, 1'b1);

    // Most negative operands
    fill(4, -128, -128);
    drive_job(4, 0, 1'b0, 1'b1);
    fill(4, -128, 127);
    drive_job(4, 0, 1'b0, 1'b1);

    // Input stalls, toggling out_ready, start poke while loading
    for (int i = 0; i < 3; i++) begin
      for (int r = 0; r < ROWS; r++) ka[i][r] = (i+1)*(r-2);
      for (int c = 0; c < COLS; c++) kb[i][c] = 7 - 3*c + i;
    end
    rdy_mode = 1;
    drive_job(3, 5, 1'b1, 1'b1);

    // Zero-length job
    rdy_mode = 0;
    drive_job(0, 0, 1'b0, 1'b1);
    check("k0_busy_low", busy, 0);

    // Abort during FLUSH, then a clean job
    fill(2, 55, -33);
    drive_job(2, 0, 1'b0, 1'b0);
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;
    q.delete();
    done_due = 1'b0;
    check_reset_outputs();
    @(posedge CLK); #1 RST = 1'b1;
    fill(1, 1, 1);
    drive_job(1, 0, 1'b0, 1'b1);

    // Long job that overflows the accumulator (wrap or saturate)
    fill(40, -128, -128);
    rdy_mode = 2;
    drive_job(40, 0, 1'b0, 1'b1);

    // Random jobs
    for (int j = 0; j < 8; j++) begin
      int k;
      k = $urandom_range(1, 12);
      for (int i = 0; i < k; i++) begin
        for (int r = 0; r < ROWS; r++) ka[i][r] = int'($urandom_range(0, 255)) - 128;
        for (int c = 0; c < COLS; c++) kb[i][c] = int'($urandom_range(0, 255)) - 128;
      end
      rdy_mode = $urandom_range(0, 2);
      drive_job(k, (j % 2) * 3, 1'b0, 1'b1);
    end

    repeat (5) @(posedge CLK);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/sa_os_tile_ctrl.md
Name: sa_os_tile_ctrl

Overview:
- Parametrised output-stationary systolic tile: a ROWS x COLS grid of signed WIDTH-bit MAC processing elements (PEs).
- Includes input skew, stall-able dataflow, a start/done FSM and a row-serial result drain with valid/ready.
- Successor to the fixed square array. Adds non-square shape, a run-time reduction length, back-pressure on both sides and a result readout path.
- Sits between the operand buffers and the result write-back.

Parameters:
- ROWS, 4, PE rows; A operands enter per row; min 2.
- COLS, 4, PE columns; B operands enter per column; min 2.
- WIDTH, 8, signed two's-complement operand width.
- ACC_W, 2*WIDTH+8, signed accumulator width per PE.
- K_W, 8, width of the reduction-length input.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  asynchronous reset, active-low.
- start  in  1  one-cycle job request; sampled only in IDLE.
- k_len  in  K_W  reduction length K, sampled with start.
- a_in  in  ROWS*WIDTH  A vector; row r at bits [r*WIDTH +: WIDTH].
- b_in  in  COLS*WIDTH  B vector; column c at bits [c*WIDTH +: WIDTH].
- in_valid  in  1  a_in/b_in beat valid.
- in_ready  out  1  tile accepts a beat.
- out_data  out  COLS*ACC_W  one result row; column c at bits [c*ACC_W +: ACC_W].
- out_row  out  clog2(ROWS)  index of the row on out_data.
- out_valid  out  1  out_data valid.
- out_ready  in  1  consumer accepts the row.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse after the last row is accepted.

Behaviour:
- Reset (RST=0, async):
  - FSM goes to IDLE.
  - All skew registers, PE pipeline registers and accumulators clear to 0.
  - in_ready=0, out_valid=0, out_row=0, busy=0, done=0.
- FSM states: IDLE, LOAD, FLUSH, DRAIN.
- IDLE:
  - On start: latch k_len, clear all accumulators in the same edge.
  - Next state is LOAD if k_len!=0, otherwise DRAIN (all results 0).
- LOAD:
  - in_ready=1.
  - A step occurs on in_valid&in_ready. Count K accepted beats, then go to FLUSH.
  - in_valid=0 stalls the whole array: no register changes and no accumulation.
- FLUSH:
  - in_ready=0. The array steps every cycle with zero operands injected.
  - Lasts exactly ROWS+COLS-1 steps, then DRAIN.
- Skew:
  - A row r is delayed r steps before entering column 0.
  - B column c is delayed c steps before entering row 0.
  - Skew registers advance only on steps.
- PE(r,c), on each step:
  - acc += x*y, with x and y sign-extended to ACC_W.
  - Forwards x right and y down, each one register per step.
  - Wrap modulo 2^ACC_W (default build).
- Final result: PE(r,c) = sum over k=0..K-1 of a_r[k]*b_c[k].
- DRAIN:
  - out_valid=1; out_row counts 0..ROWS-1.
  - out_data is stable while out_valid&!out_ready.
  - Advance on out_valid&out_ready.
  - After row ROWS-1 is accepted: done=1 for one cycle, out_valid=0, return to IDLE.
- start while busy is ignored; no queueing.
- Reset asserted mid-job aborts the job immediately with no done pulse.
- The accumulator is combinational-multiply then register: one PE register stage.
- Latency from last accepted beat to first out_valid = ROWS+COLS-1 cycles, plus 1 FSM cycle.

Optional Feature:
- Macro: SA_ACC_SAT_EN.
- Defined: PE accumulation saturates to +2^(ACC_W-1)-1 or -2^(ACC_W-1) instead of wrapping. Saturation is sticky until the next start clear.
- Undefined: two's-complement wrap.

Test Plan:
- ROWS=COLS=4, K=1, a=(1,2,3,4), b=(5,6,7,8) -> row r col c = (r+1)*(c+5); row 3 = (20,24,28,32); done once.
- K=4, a_r[k]=-128, b_c[k]=-128 -> every result 65536; repeat with b=127 -> every result -65024.
- K=3 with in_valid deasserted 5 cycles between beats, out_ready toggling 1/0 -> results identical to the no-stall run; out_data held while out_ready=0.
- k_len=0 -> no in_ready; 4 rows of zeros; done pulse; busy falls.
- RST low during FLUSH of a K=2 job, then a new job K=1 with a=b=all 1 -> all results 1; no stale data; no done from the aborted job.
- ACC_W=12 with SA_ACC_SAT_EN, K=1 with 127*127=16129, then (new start) K=2 of 127*127 -> results 2047 (saturated); without the macro K=1 -> 16129 mod 4096 = 3841, read as signed -255.
